// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: accepts HI/LO-class ops from EXE, launches the external multiplier or divider,
// and commits results into the architectural HI/LO pair. A flush discards the op in flight.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        req_ready,
  input  logic        flush,
  output logic        mul_begin,
  output logic        mul_signed,
  input  logic        mul_end,
  input  logic [63:0] mul_product,
  output logic        div_begin,
  output logic        div_signed,
  input  logic        div_end,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic [31:0] unit_op1,
  output logic [31:0] unit_op2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DRAIN} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] hi_q, lo_q, op1_q, op2_q;
  logic        mul_begin_q, div_begin_q, mul_signed_q, div_signed_q, done_q;

  logic        is_mul_op, is_div_op, drain_is_div, drain_end;
  logic [63:0] madd_sum_d;

  // Accumulate with the carry out of bit 63 dropped.
  function automatic logic [63:0] wrap_add64(input logic [63:0] a, input logic [63:0] b);
    return a + b;
  endfunction

  assign is_mul_op    = (req_op == OP_MULT) || (req_op == OP_MULTU) || (req_op == OP_MADD);
  assign is_div_op    = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign drain_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign drain_end    = drain_is_div ? div_end : mul_end;
  assign madd_sum_d   = wrap_add64({hi_q, lo_q}, mul_product);

  assign req_ready  = req_valid & (state_q == IDLE) & ~flush;
  assign busy       = (state_q != IDLE) | (req_ready & (is_mul_op | is_div_op));
  assign mul_begin  = mul_begin_q;
  assign div_begin  = div_begin_q;
  assign mul_signed = mul_signed_q;
  assign div_signed = div_signed_q;
  assign unit_op1   = op1_q;
  assign unit_op2   = op2_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_MULT;
      hi_q         <= '0;
      lo_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      mul_begin_q  <= 1'b0;
      div_begin_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      mul_begin_q <= 1'b0;
      div_begin_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_ready) begin
            if (req_op == OP_MTHI) begin
              hi_q   <= req_op1;
              done_q <= 1'b1;
            end else if (req_op == OP_MTLO) begin
              lo_q   <= req_op1;
              done_q <= 1'b1;
            end else if (is_mul_op) begin
              op_q         <= req_op;
              op1_q        <= req_op1;
              op2_q        <= req_op2;
              mul_signed_q <= (req_op != OP_MULTU);
              mul_begin_q  <= 1'b1;
              state_q      <= MUL;
            end else if (is_div_op) begin
              op_q         <= req_op;
              op1_q        <= req_op1;
              op2_q        <= req_op2;
              div_signed_q <= (req_op == OP_DIV);
              div_begin_q  <= 1'b1;
              state_q      <= DIV;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state_q <= mul_end ? IDLE : DRAIN;
          end else if (mul_end) begin
            if (op_q == OP_MADD) begin
              {hi_q, lo_q} <= madd_sum_d;
            end else begin
              {hi_q, lo_q} <= mul_product;
            end
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        DIV: begin
          if (flush) begin
            state_q <= div_end ? IDLE : DRAIN;
          end else if (div_end) begin
            // Divide by zero leaves HI/LO untouched but still completes.
            if (op2_q != 32'd0) begin
              lo_q <= div_quot;
              hi_q <= div_rem;
            end
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a table of single ops with a mock unit, then hand-written
// sequences for flush, drain, ignored end strobes and mid-op reset.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, mul_end, div_end;
  logic [2:0]  req_op;
  logic [31:0] req_op1, req_op2, div_quot, div_rem;
  logic [63:0] mul_product;
  logic        req_ready, mul_begin, mul_signed, div_begin, div_signed, busy, done;
  logic [31:0] unit_op1, unit_op2, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] rh, rl;
    logic [31:0] eh, el;
    logic        sgn;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready), .flush(flush),
    .mul_begin(mul_begin), .mul_signed(mul_signed), .mul_end(mul_end),
    .mul_product(mul_product), .div_begin(div_begin), .div_signed(div_signed),
    .div_end(div_end), .div_quot(div_quot), .div_rem(div_rem),
    .unit_op1(unit_op1), .unit_op2(unit_op2), .hi(hi), .lo(lo),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic  is_mul, is_div;
    tag    = $sformatf("v%0d", idx);
    is_mul = (v.op == OP_MULT) || (v.op == OP_MULTU) || (v.op == OP_MADD);
    is_div = (v.op == OP_DIV) || (v.op == OP_DIVU);
    req_valid = 1'b1; req_op = v.op; req_op1 = v.a; req_op2 = v.b;
    #1;
    chk({tag, ".ready"}, req_ready, 1);
    chk({tag, ".busy_acc"}, busy, is_mul | is_div);
    step();
    req_valid = 1'b0; req_op = OP_NOP;
    #1;
    if (is_mul || is_div) begin
      chk({tag, ".begin"}, is_mul ? mul_begin : div_begin, 1);
      chk({tag, ".other_begin"}, is_mul ? div_begin : mul_begin, 0);
      chk({tag, ".signed"}, is_mul ? mul_signed : div_signed, v.sgn);
      chk({tag, ".uop1"}, unit_op1, v.a);
      chk({tag, ".uop2"}, unit_op2, v.b);
      chk({tag, ".busy_c1"}, busy, 1);
      for (int k = 1; k < v.lat; k++) begin
        step();
        chk({tag, ".begin_off"}, mul_begin | div_begin, 0);
        chk({tag, ".busy_wait"}, busy, 1);
        chk({tag, ".done_wait"}, done, 0);
      end
      step();
      if (is_mul) begin
        mul_end = 1'b1; mul_product = {v.rh, v.rl};
      end else begin
        div_end = 1'b1; div_quot = v.rl; div_rem = v.rh;
      end
      step();
      mul_end = 1'b0; div_end = 1'b0;
      #1;
    end
    chk({tag, ".done"}, done, v.op != OP_NOP);
    chk({tag, ".hi"}, hi, v.eh);
    chk({tag, ".lo"}, lo, v.el);
    chk({tag, ".busy_end"}, busy, 0);
    step();
    chk({tag, ".done_off"}, done, 0);
  endtask

  initial begin
    vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0, 0, 32'h0, 32'h0, 32'h12345678, 32'h00000000, 1'b0};
    vecs[1]  = '{OP_MTLO,  32'hCAFEBABE, 32'h0, 0, 32'h0, 32'h0, 32'h12345678, 32'hCAFEBABE, 1'b0};
    vecs[2]  = '{OP_MULT,  32'hFFFFFFFF, 32'h2, 3, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2, 1, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{OP_MTHI,  32'hFFFFFFFF, 32'h0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[5]  = '{OP_MTLO,  32'hFFFFFFFF, 32'h0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{OP_MADD,  32'h1, 32'h1, 2, 32'h0, 32'h1, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{OP_DIVU,  32'h7, 32'h2, 4, 32'h1, 32'h3, 32'h1, 32'h3, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'h0, 2, 32'hBEEF, 32'hDEAD, 32'h1, 32'h3, 1'b1};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2, 3, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
    vecs[10] = '{OP_MADD,  32'h2, 32'h3, 2, 32'h0, 32'h6, 32'h0, 32'h3, 1'b1};
    vecs[11] = '{OP_NOP,   32'h5, 32'h6, 0, 32'h0, 32'h0, 32'h0, 32'h3, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_op1 = '0; req_op2 = '0;
    flush = 1'b0; mul_end = 1'b0; div_end = 1'b0; mul_product = '0; div_quot = '0; div_rem = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.begins", {mul_begin, div_begin, mul_signed, div_signed}, 0);
    chk("rst.uops", {unit_op1, unit_op2}, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Flush two cycles into DIV; div_end arrives five cycles after the flush.
    req_valid = 1'b1; req_op = OP_DIVU; req_op1 = 32'd9; req_op2 = 32'd3;
    step();
    req_op = OP_NOP;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl_div.busy", busy, 1);
    chk("fl_div.ready", req_ready, 0);
    chk("fl_div.done", done, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fl_div.ready_drain", req_ready, 0);
      chk("fl_div.done_drain", done, 0);
    end
    div_end = 1'b1; div_quot = 32'h55; div_rem = 32'h66;
    #1;
    chk("fl_div.ready_end", req_ready, 0);
    step();
    div_end = 1'b0;
    #1;
    chk("fl_div.ready_idle", req_ready, 1);
    chk("fl_div.busy_idle", busy, 0);
    chk("fl_div.done_idle", done, 0);
    chk("fl_div.hilo", {hi, lo}, 64'h0000000000000003);
    req_valid = 1'b0;
    step();
    chk("fl_div.done_late", done, 0);

    // Flush coincident with mul_end: flush wins.
    req_valid = 1'b1; req_op = OP_MULT; req_op1 = 32'd5; req_op2 = 32'd5;
    step();
    req_valid = 1'b0; req_op = OP_NOP;
    step();
    mul_end = 1'b1; mul_product = 64'd25; flush = 1'b1;
    step();
    mul_end = 1'b0; flush = 1'b0;
    #1;
    chk("fl_mul.busy", busy, 0);
    chk("fl_mul.done", done, 0);
    chk("fl_mul.hilo", {hi, lo}, 64'h0000000000000003);
    req_valid = 1'b1;
    #1;
    chk("fl_mul.ready_idle", req_ready, 1);
    req_valid = 1'b0;
    step();
    chk("fl_mul.done_late", done, 0);

    // MTLO presented together with flush must not write.
    req_valid = 1'b1; req_op = OP_MTLO; req_op1 = 32'h1111; flush = 1'b1;
    #1;
    chk("fl_mtlo.ready", req_ready, 0);
    step();
    req_valid = 1'b0; req_op = OP_NOP; flush = 1'b0;
    #1;
    chk("fl_mtlo.lo", lo, 32'h3);
    chk("fl_mtlo.done", done, 0);

    // mul_end while in DIV is ignored.
    req_valid = 1'b1; req_op = OP_DIVU; req_op1 = 32'd8; req_op2 = 32'd2;
    step();
    req_valid = 1'b0; req_op = OP_NOP;
    step();
    mul_end = 1'b1; mul_product = 64'hFFFF;
    step();
    mul_end = 1'b0;
    #1;
    chk("xend.done", done, 0);
    chk("xend.busy", busy, 1);
    chk("xend.hilo", {hi, lo}, 64'h0000000000000003);
    div_end = 1'b1; div_quot = 32'd4; div_rem = 32'd0;
    step();
    div_end = 1'b0;
    #1;
    chk("xend.done_div", done, 1);
    chk("xend.hilo_div", {hi, lo}, 64'h0000000000000004);

    // Reset in MUL, then a stale mul_end in IDLE.
    req_valid = 1'b1; req_op = OP_MULT; req_op1 = 32'd3; req_op2 = 32'd4;
    step();
    req_valid = 1'b0; req_op = OP_NOP;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_mul.hilo", {hi, lo}, 0);
    chk("rst_mul.busy", busy, 0);
    chk("rst_mul.done", done, 0);
    chk("rst_mul.state", {mul_begin, mul_signed, unit_op1}, 0);
    mul_end = 1'b1; mul_product = 64'h12345678;
    step();
    mul_end = 1'b0;
    #1;
    chk("rst_mul.stale_hilo", {hi, lo}, 0);
    chk("rst_mul.stale_done", done, 0);
    chk("rst_mul.stale_busy", busy, 0);
    step();
    chk("rst_mul.done_late", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports as follows. Clock and reset come first.
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE offers a HI/LO-class op this cycle
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MTHI, 110 MTLO, 111 no-op
- req_op1, req_op2  in  32  rs / rt operand values
- req_ready  out  1  request accepted this cycle
- flush  in  1  exception/eret cancel of the in-flight op
- mul_begin  out  1  1-cycle start pulse to the multiplier
- mul_signed  out  1  multiplier sign mode
- mul_end  in  1  multiplier result valid
- mul_product  in  64  multiplier result
- div_begin  out  1  1-cycle start pulse to the divider
- div_signed  out  1  divider sign mode
- div_end  in  1  divider result valid
- div_quot, div_rem  in  32  divider results
- unit_op1, unit_op2  out  32  latched operands driven to both units
- hi, lo  out  32  architectural HI/LO
- busy  out  1  an op is in flight (stalls mfhi/mflo and new requests)
- done  out  1  1-cycle pulse when HI/LO commit

Function
REQ-002 SHALL implement FSM states IDLE, MUL, DIV, DRAIN.
REQ-003 SHALL assert req_ready = req_valid & (state==IDLE) & ~flush; a request is accepted only when req_ready=1.
REQ-004 SHALL, on an accepted MTHI, write hi<=req_op1 and stay in IDLE; SHALL, on an accepted MTLO, write lo<=req_op1 and stay in IDLE; done SHALL pulse in the following cycle.
REQ-005 SHALL, on an accepted MULT, MULTU or MADD:
- latch req_op1 and req_op2 into unit_op1 and unit_op2;
- set mul_signed to 1 for MULT and MADD, 0 for MULTU;
- assert mul_begin for exactly one cycle, the cycle after acceptance;
- enter MUL.
REQ-006 SHALL, on an accepted DIV or DIVU, do the same as REQ-005 with div_begin/div_signed (div_signed=1 for DIV), then enter DIV.
REQ-007 SHALL, in MUL when mul_end=1:
- for MULT/MULTU, write {hi,lo}<=mul_product;
- for MADD, write {hi,lo}<={hi,lo}+mul_product using a 64-bit add with the carry out discarded (wraps modulo 2^64);
- pulse done and return to IDLE.
REQ-008 SHALL, in DIV when div_end=1:
- write lo<=div_quot and hi<=div_rem;
- pulse done and return to IDLE;
- if the latched unit_op2==0, leave HI/LO unchanged but still pulse done.
REQ-009 SHALL hold busy=1 in MUL, DIV and DRAIN, and on the cycle a MULT/MULTU/MADD/DIV/DIVU is accepted; busy=0 otherwise.
REQ-010 SHALL, on flush=1 in MUL or DIV with no *_end that cycle, discard the op (no HI/LO write, no done) and enter DRAIN.
REQ-011 SHALL, on flush=1 in MUL or DIV while *_end=1, treat the flush as winning: no write and no done, go to IDLE.
REQ-012 SHALL, in DRAIN, wait for the pending unit's *_end, discard its result, then go to IDLE; flush in DRAIN SHALL have no extra effect.
REQ-013 SHALL, on flush in IDLE, block acceptance that cycle; an MTHI/MTLO presented with flush=1 SHALL NOT write.
REQ-014 SHALL ignore mul_end in DIV and div_end in MUL.
REQ-015 SHALL keep mul_begin and div_begin mutually exclusive and never assert either outside the cycle after acceptance.
REQ-016 SHALL treat req_op=111 as a no-op: req_ready may assert, but there is no state change and no done.

Reset
REQ-017 SHALL, on reset=1 at a clock edge, set state=IDLE, hi=0, lo=0, unit_op1=unit_op2=0, mul_begin=div_begin=0, mul_signed=div_signed=0, done=0 and busy=0.
REQ-018 SHALL, on reset mid-operation, abandon the op with no HI/LO write; a later stale *_end seen in IDLE SHALL be ignored.
REQ-019 SHALL let reset take priority over flush and all requests.

Verification
REQ-020 SHALL verify MULT with 0xFFFFFFFF x 0x00000002 and mul_end 3 cycles after mul_begin: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done one cycle, busy 1 throughout.
REQ-021 SHALL verify MADD with prior {hi,lo}=0xFFFFFFFF_FFFFFFFF and product 1: {hi,lo}=0 (wrap), mul_signed=1.
REQ-022 SHALL verify DIVU 7/2: lo=3, hi=1; DIV 0x80000000/0 with div_end asserted: HI/LO unchanged, done pulses.
REQ-023 SHALL verify flush 2 cycles into DIV, with div_end arriving 5 cycles later: DRAIN entered, no write, no done, req_ready=0 until IDLE.
REQ-024 SHALL verify flush coincident with mul_end: no write, IDLE next cycle; MTLO with flush=1: lo unchanged.
REQ-025 SHALL verify reset asserted in MUL followed by a stale mul_end: state IDLE, hi=lo=0, done stays 0.
